vga_addr_gen: RTL

- Pipelined, parametrised framebuffer read-address generator for the VGA path.
- Sits between the VGA timing controller (hCounter/vCounter) and the video RAM read port.
- Replaces the per-pixel multiply with incremental row/column counters.
- Adds pixel scaling, blanking/valid qualification, counter-sequence checking and optional double-buffered frame select.

---
 rtl/vga_pkg.sv | 17 +
 rtl/vga_scale_cnt.sv | 39 +++
 rtl/vga_addr_gen.sv | 139 +++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared state encoding, default timing and frame-geometry helpers for the VGA address path.
package vga_pkg;

    typedef enum logic [1:0] {SYNC_WAIT, ACTIVE, HBLANK, VBLANK} state_t;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_V_ACTIVE = 480;

    function automatic int calc_lw(input int h_active, input int shift);
        return h_active >> shift;
    endfunction

    function automatic int calc_fw(input int h_active, input int v_active, input int shift);
        return calc_lw(h_active, shift) * (v_active >> shift);
    endfunction

endpackage

// File: rtl/vga_scale_cnt.sv
// vga_scale_cnt: source-column counter that advances once every 2^SHIFT emitted pixels.
module vga_scale_cnt #(
    parameter int CW    = 10,
    parameter int SHIFT = 0
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          start_i,
    input  logic          step_i,
    output logic [CW-1:0] col_o
);

    localparam int SW = (SHIFT > 0) ? SHIFT : 1;
    localparam logic [SW-1:0] M = SW'((1 << SHIFT) - 1);

    logic [CW-1:0] col_q, col_d, col_cur;
    logic [SW-1:0] sub_q, sub_d, sub_cur;

    // The first pixel of a line uses column 0 regardless of what is stored.
    always_comb begin
        col_cur = start_i ? '0 : col_q;
        sub_cur = start_i ? '0 : sub_q;
        sub_d   = step_i ? ((sub_cur == M) ? '0 : sub_cur + 1'b1) : '0;
        col_d   = step_i ? ((sub_cur == M) ? col_cur + 1'b1 : col_cur) : '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            col_q <= '0;
            sub_q <= '0;
        end else begin
            col_q <= col_d;
            sub_q <= sub_d;
        end
    end

    assign col_o = col_cur;

endmodule

// File: rtl/vga_addr_gen.sv
// vga_addr_gen: incremental framebuffer read-address generator with scaling and sequence checking.
// Define VGA_ADDR_DBUF_EN to select the frame buffer per frame from frame_sel.
module vga_addr_gen
    import vga_pkg::*;
#(
    parameter int CW          = 10,
    parameter int AW          = 20,
    parameter int H_ACTIVE    = DEF_H_ACTIVE,
    parameter int V_ACTIVE    = DEF_V_ACTIVE,
    parameter int SCALE_SHIFT = 0,
    parameter int ADDR_OFFSET = 1,
    parameter int BASE_ADDR   = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic [CW-1:0] hCounter,
    input  logic [CW-1:0] vCounter,
    input  logic          frame_sel,
    output logic [AW-1:0] addr,
    output logic          addr_valid,
    output logic          line_start,
    output logic          frame_done,
    output logic          sync_err
);

    localparam int LW = calc_lw(H_ACTIVE, SCALE_SHIFT);
    localparam int FW = calc_fw(H_ACTIVE, V_ACTIVE, SCALE_SHIFT);
    localparam logic [CW-1:0] VM     = CW'((1 << SCALE_SHIFT) - 1);
    localparam logic [CW-1:0] H_LAST = CW'(H_ACTIVE - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_ACTIVE - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] h_q, v_q, col;
    logic [AW-1:0] row_q, row_d, fbase_q, fbase_d, addr_q, addr_d;
    logic [AW-1:0] row_cur, fbase_cur;
    logic          valid_q, valid_d, ls_q, ls_d, fd_q, fd_d, err_q, err_d;
    logic          origin, h_seq, v_seq, emit, line_first, frame_first, fb;

`ifdef VGA_ADDR_DBUF_EN
    assign fb = frame_sel;
`else
    logic unused_frame_sel;
    assign unused_frame_sel = frame_sel;
    assign fb = 1'b0;
`endif

    vga_scale_cnt #(.CW(CW), .SHIFT(SCALE_SHIFT)) u_hcnt (
        .clk_i   (clk),
        .rst_ni  (rst),
        .start_i (line_first | frame_first),
        .step_i  (emit),
        .col_o   (col)
    );

    always_comb begin
        origin      = (hCounter == '0) && (vCounter == '0);
        h_seq       = hCounter == h_q + 1'b1;
        v_seq       = vCounter == v_q + 1'b1;
        state_d     = state_q;
        row_d       = row_q;
        fbase_d     = fbase_q;
        addr_d      = addr_q;
        valid_d     = 1'b0;
        ls_d        = 1'b0;
        fd_d        = 1'b0;
        err_d       = 1'b0;
        emit        = 1'b0;
        line_first  = 1'b0;
        frame_first = 1'b0;
        if (!enable) begin
            state_d = SYNC_WAIT;
        end else begin
            case (state_q)
                SYNC_WAIT, VBLANK: begin
                    emit        = origin;
                    frame_first = origin;
                end
                ACTIVE: begin
                    emit  = h_seq && (vCounter == v_q);
                    err_d = !emit;
                end
                HBLANK: begin
                    emit       = (hCounter == '0) && v_seq;
                    line_first = emit;
                    err_d      = !emit && ((hCounter == '0) || !h_seq || (vCounter != v_q));
                end
                default: state_d = SYNC_WAIT;
            endcase
            if (err_d) state_d = SYNC_WAIT;
        end
        // A new source row starts only on lines that are not vertical repeats.
        fbase_cur = frame_first ? AW'(BASE_ADDR) + (fb ? AW'(FW) : '0) : fbase_q;
        row_cur   = frame_first ? '0 :
                    (line_first && ((vCounter & VM) == '0)) ? row_q + AW'(LW) : row_q;
        if (emit) begin
            addr_d  = fbase_cur + AW'(ADDR_OFFSET) + row_cur + AW'(col);
            valid_d = 1'b1;
            ls_d    = frame_first || line_first;
            fd_d    = (hCounter == H_LAST) && (vCounter == V_LAST);
            row_d   = row_cur;
            fbase_d = fbase_cur;
            state_d = (hCounter != H_LAST) ? ACTIVE : (vCounter == V_LAST) ? VBLANK : HBLANK;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= SYNC_WAIT;
            h_q     <= '0;
            v_q     <= '0;
            row_q   <= '0;
            fbase_q <= '0;
            addr_q  <= '0;
            valid_q <= 1'b0;
            ls_q    <= 1'b0;
            fd_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            h_q     <= hCounter;
            v_q     <= vCounter;
            row_q   <= row_d;
            fbase_q <= fbase_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            ls_q    <= ls_d;
            fd_q    <= fd_d;
            err_q   <= err_d;
        end
    end

    assign addr       = addr_q;
    assign addr_valid = valid_q;
    assign line_start = ls_q;
    assign frame_done = fd_q;
    assign sync_err   = err_q;

endmodule
